// File: rtl/apb_ucpd_tx_sched.sv
// UCPD transmit scheduler: arbitrates message and hard-reset requests and walks the
// clock generator through interframe gap, transition window and BMC phases.
module apb_ucpd_tx_sched #(
    parameter int unsigned TO_HBITS = 1023
) (
    input  logic ic_clk,
    input  logic ic_rst_n,
    input  logic ucpd_en,
    input  logic tx_send,
    input  logic tx_hrst_req,
    input  logic rx_active,
    input  logic ifrgap_en,
    input  logic transwin_en,
    input  logic hbit_clk_red,
    input  logic tx_eop_cmplt,
    input  logic tx_sop_rst_cmplt,
    output logic wait_en,
    output logic transmit_en,
    output logic bmc_en,
    output logic tx_hrst,
    output logic tx_busy,
    output logic txmsgsent,
    output logic txmsgdisc,
    output logic txmsgabt,
    output logic hrstsent,
    output logic hrstdisc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        WIN  = 2'd2,
        BMC  = 2'd3
    } state_t;

    typedef enum logic {
        KIND_MSG  = 1'b0,
        KIND_HRST = 1'b1
    } kind_t;

    localparam logic [9:0] WDOG_LAST = 10'(TO_HBITS - 1);

    state_t     state;
    state_t     state_nxt;
    kind_t      kind;
    kind_t      kind_nxt;
    logic       msg_pend;
    logic       hrst_pend;
    logic       msg_take;
    logic       hrst_take;
    logic [9:0] wdog_cnt;
    logic [9:0] wdog_nxt;
    logic       wdog_hit;
    logic       sent_nxt;
    logic       disc_nxt;
    logic       abt_nxt;
    logic       hsent_nxt;
    logic       hdisc_nxt;

    // Requests are single-cycle pulses latched into pend flags; strobes from the
    // clock generator and encoder are sampled only in the state that waits on them.
    assign wdog_hit = hbit_clk_red && (wdog_cnt == WDOG_LAST);

    always_comb begin
        state_nxt = state;
        kind_nxt  = kind;
        wdog_nxt  = wdog_cnt;
        msg_take  = 1'b0;
        hrst_take = 1'b0;
        sent_nxt  = 1'b0;
        disc_nxt  = 1'b0;
        abt_nxt   = 1'b0;
        hsent_nxt = 1'b0;
        hdisc_nxt = 1'b0;
        if (!ucpd_en) begin
            state_nxt = IDLE;
            kind_nxt  = KIND_MSG;
            wdog_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    wdog_nxt = '0;
                    if (hrst_pend) begin
                        state_nxt = GAP;
                        kind_nxt  = KIND_HRST;
                        hrst_take = 1'b1;
                    end else if (msg_pend) begin
                        msg_take = 1'b1;
                        if (rx_active) begin
                            disc_nxt = 1'b1;
                        end else begin
                            state_nxt = GAP;
                            kind_nxt  = KIND_MSG;
                        end
                    end
                end
                GAP: begin
                    // A message yields to a pending hard reset, which reuses the gap.
                    if (kind == KIND_MSG && hrst_pend) begin
                        disc_nxt  = 1'b1;
                        kind_nxt  = KIND_HRST;
                        hrst_take = 1'b1;
                    end else if (kind == KIND_MSG && rx_active) begin
                        disc_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else if (ifrgap_en) begin
                        state_nxt = WIN;
                    end
                end
                WIN: begin
                    if (transwin_en) begin
                        state_nxt = BMC;
                        wdog_nxt  = '0;
                    end
                end
                BMC: begin
                    if (hbit_clk_red) begin
                        wdog_nxt = wdog_cnt + 10'd1;
                    end
                    if (kind == KIND_HRST) begin
                        if (tx_sop_rst_cmplt) begin
                            hsent_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else if (wdog_hit) begin
                            hdisc_nxt = 1'b1;
                            state_nxt = IDLE;
                        end
                    end else begin
                        // Completion beats a late hard reset; that one starts from IDLE.
                        if (tx_eop_cmplt) begin
                            sent_nxt  = 1'b1;
                            state_nxt = IDLE;
                        end else if (hrst_pend) begin
                            abt_nxt   = 1'b1;
                            kind_nxt  = KIND_HRST;
                            hrst_take = 1'b1;
                            state_nxt = GAP;
                        end else if (wdog_hit) begin
                            abt_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge ic_clk or negedge ic_rst_n) begin
        if (!ic_rst_n) begin
            state       <= IDLE;
            kind        <= KIND_MSG;
            wdog_cnt    <= '0;
            msg_pend    <= 1'b0;
            hrst_pend   <= 1'b0;
            wait_en     <= 1'b0;
            transmit_en <= 1'b0;
            bmc_en      <= 1'b0;
            tx_hrst     <= 1'b0;
            txmsgsent   <= 1'b0;
            txmsgdisc   <= 1'b0;
            txmsgabt    <= 1'b0;
            hrstsent    <= 1'b0;
            hrstdisc    <= 1'b0;
        end else begin
            state       <= state_nxt;
            kind        <= kind_nxt;
            wdog_cnt    <= wdog_nxt;
            msg_pend    <= ucpd_en && ((msg_pend && !msg_take) || tx_send);
            hrst_pend   <= ucpd_en && ((hrst_pend && !hrst_take) || tx_hrst_req);
            wait_en     <= (state_nxt == GAP);
            transmit_en <= (state_nxt == WIN) || (state_nxt == BMC);
            bmc_en      <= (state_nxt == BMC);
            tx_hrst     <= ((state_nxt == WIN) || (state_nxt == BMC)) && (kind_nxt == KIND_HRST);
            txmsgsent   <= sent_nxt;
            txmsgdisc   <= disc_nxt;
            txmsgabt    <= abt_nxt;
            hrstsent    <= hsent_nxt;
            hrstdisc    <= hdisc_nxt;
        end
    end

    assign tx_busy = (state != IDLE) || msg_pend || hrst_pend;

endmodule

// File: tb/tb_apb_ucpd_tx_sched.sv
// Bench for apb_ucpd_tx_sched: directed scenarios with hand-derived timing,
// then random traffic against a frame-level reference model.
module tb_apb_ucpd_tx_sched;

    localparam int TB_TO = 8;
    localparam int P_IDLE = 0;
    localparam int P_GAP  = 1;
    localparam int P_WIN  = 2;
    localparam int P_BMC  = 3;

    logic ic_clk = 1'b0;
    logic ic_rst_n = 1'b0;
    logic ucpd_en = 1'b1;
    logic tx_send = 1'b0;
    logic tx_hrst_req = 1'b0;
    logic rx_active = 1'b0;
    logic ifrgap_en = 1'b0;
    logic transwin_en = 1'b0;
    logic hbit_clk_red = 1'b0;
    logic tx_eop_cmplt = 1'b0;
    logic tx_sop_rst_cmplt = 1'b0;
    logic wait_en, transmit_en, bmc_en, tx_hrst, tx_busy;
    logic txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc;
    logic [9:0] obs;
    logic [9:0] exp_obs;

    int checks = 0;
    int failures = 0;

    // reference model: one frame in flight plus the two request flags
    int m_phase;
    bit m_is_hrst;
    bit m_mp;
    bit m_hp;
    int m_hbits;

    apb_ucpd_tx_sched #(.TO_HBITS(TB_TO)) dut (
        .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpd_en(ucpd_en),
        .tx_send(tx_send), .tx_hrst_req(tx_hrst_req), .rx_active(rx_active),
        .ifrgap_en(ifrgap_en), .transwin_en(transwin_en), .hbit_clk_red(hbit_clk_red),
        .tx_eop_cmplt(tx_eop_cmplt), .tx_sop_rst_cmplt(tx_sop_rst_cmplt),
        .wait_en(wait_en), .transmit_en(transmit_en), .bmc_en(bmc_en), .tx_hrst(tx_hrst),
        .tx_busy(tx_busy), .txmsgsent(txmsgsent), .txmsgdisc(txmsgdisc),
        .txmsgabt(txmsgabt), .hrstsent(hrstsent), .hrstdisc(hrstdisc)
    );

    assign obs = {wait_en, transmit_en, bmc_en, tx_hrst, tx_busy,
                  txmsgsent, txmsgdisc, txmsgabt, hrstsent, hrstdisc};

    always #5 ic_clk = ~ic_clk;

    task automatic model_reset();
        m_phase = P_IDLE;
        m_is_hrst = 1'b0;
        m_mp = 1'b0;
        m_hp = 1'b0;
        m_hbits = 0;
        exp_obs = '0;
    endtask

    task automatic model_step();
        bit take_m, take_h, done;
        bit e_sent, e_disc, e_abt, e_hsent, e_hdisc;
        bit in_frame;
        take_m = 0; take_h = 0; done = 0;
        e_sent = 0; e_disc = 0; e_abt = 0; e_hsent = 0; e_hdisc = 0;
        if (!ucpd_en) begin
            m_phase = P_IDLE; m_is_hrst = 0; m_mp = 0; m_hp = 0; m_hbits = 0;
        end else begin
            if (m_phase == P_IDLE) begin
                if (m_hp) begin
                    m_phase = P_GAP; m_is_hrst = 1; take_h = 1;
                end else if (m_mp) begin
                    take_m = 1;
                    if (rx_active) e_disc = 1;
                    else begin m_phase = P_GAP; m_is_hrst = 0; end
                end
            end else if (m_phase == P_GAP) begin
                if (!m_is_hrst && m_hp) begin
                    e_disc = 1; m_is_hrst = 1; take_h = 1;
                end else if (!m_is_hrst && rx_active) begin
                    e_disc = 1; m_phase = P_IDLE;
                end else if (ifrgap_en) m_phase = P_WIN;
            end else if (m_phase == P_WIN) begin
                if (transwin_en) begin m_phase = P_BMC; m_hbits = 0; end
            end else begin
                done = m_is_hrst ? tx_sop_rst_cmplt : tx_eop_cmplt;
                if (done) begin
                    if (m_is_hrst) e_hsent = 1; else e_sent = 1;
                    m_phase = P_IDLE;
                end else if (!m_is_hrst && m_hp) begin
                    e_abt = 1; m_is_hrst = 1; take_h = 1; m_phase = P_GAP;
                end else if (hbit_clk_red) begin
                    m_hbits = m_hbits + 1;
                    if (m_hbits >= TB_TO) begin
                        if (m_is_hrst) e_hdisc = 1; else e_abt = 1;
                        m_phase = P_IDLE;
                    end
                end
            end
            m_mp = (m_mp && !take_m) || tx_send;
            m_hp = (m_hp && !take_h) || tx_hrst_req;
        end
        in_frame = (m_phase == P_WIN) || (m_phase == P_BMC);
        exp_obs = {m_phase == P_GAP, in_frame, m_phase == P_BMC, in_frame && m_is_hrst,
                   (m_phase != P_IDLE) || m_mp || m_hp,
                   e_sent, e_disc, e_abt, e_hsent, e_hdisc};
    endtask

    // one clock: inputs already set by the caller, outputs readable on return
    task automatic tick();
        model_step();
        @(posedge ic_clk);
        #1;
        tx_send = 0; tx_hrst_req = 0; ifrgap_en = 0; transwin_en = 0;
        hbit_clk_red = 0; tx_eop_cmplt = 0; tx_sop_rst_cmplt = 0;
    endtask

    task automatic test_reset();
        ic_rst_n = 0;
        repeat (3) @(posedge ic_clk);
        #1;
        checks++;
        if (obs !== 10'b0) begin failures++; $display("FAIL reset_por obs=%b exp=%b", obs, 10'b0); end
        ic_rst_n = 1;
        model_reset();
        tx_send = 1; tick();
        tick();
        ifrgap_en = 1; tick();
        transwin_en = 1; tick();
        tick(); tick();
        checks++;
        if (bmc_en !== 1'b1) begin failures++; $display("FAIL reset_pre_bmc bmc_en=%b exp=1", bmc_en); end
        ic_rst_n = 0;
        #2;
        checks++;
        if (obs !== 10'b0) begin failures++; $display("FAIL reset_async obs=%b exp=%b", obs, 10'b0); end
        @(posedge ic_clk);
        #1;
        ic_rst_n = 1;
        model_reset();
        checks++;
        if (obs !== 10'b0) begin failures++; $display("FAIL reset_release obs=%b exp=%b", obs, 10'b0); end
        tick();
        checks++;
        if (obs !== 10'b0) begin failures++; $display("FAIL reset_idle obs=%b exp=%b", obs, 10'b0); end
    endtask

    task automatic test_msg_send();
        int n_wait, n_tx, n_bmc, n_sent, first_wait, sent_at, n_bad;
        n_wait = 0; n_tx = 0; n_bmc = 0; n_sent = 0; first_wait = -1; sent_at = -1; n_bad = 0;
        for (int c = 0; c < 22; c++) begin
            tx_send = (c == 0); ifrgap_en = (c == 4); transwin_en = (c == 6); tx_eop_cmplt = (c == 16);
            tick();
            if (wait_en) begin n_wait++; if (first_wait < 0) first_wait = c + 1; end
            if (transmit_en) n_tx++;
            if (bmc_en) n_bmc++;
            if (txmsgsent) begin n_sent++; sent_at = c + 1; end
            if (tx_hrst || txmsgdisc || txmsgabt || hrstsent || hrstdisc) n_bad++;
        end
        checks++; if (n_wait !== 3) begin failures++; $display("FAIL msg_wait_len got=%0d exp=3", n_wait); end
        checks++; if (first_wait !== 2) begin failures++; $display("FAIL msg_wait_start got=%0d exp=2", first_wait); end
        checks++; if (n_tx !== 12) begin failures++; $display("FAIL msg_tx_len got=%0d exp=12", n_tx); end
        checks++; if (n_bmc !== 10) begin failures++; $display("FAIL msg_bmc_len got=%0d exp=10", n_bmc); end
        checks++; if (n_sent !== 1 || sent_at !== 17) begin failures++; $display("FAIL msg_sent n=%0d at=%0d exp n=1 at=17", n_sent, sent_at); end
        checks++; if (n_bad !== 0) begin failures++; $display("FAIL msg_stray got=%0d exp=0", n_bad); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL msg_busy_end got=%b exp=0", tx_busy); end
    endtask

    task automatic test_rx_discard();
        int n_wait, n_disc, disc_at;
        logic busy3;
        n_wait = 0; n_disc = 0; disc_at = -1; busy3 = 1'bx;
        rx_active = 1;
        for (int c = 0; c < 6; c++) begin
            tx_send = (c == 0);
            tick();
            if (wait_en) n_wait++;
            if (txmsgdisc) begin n_disc++; disc_at = c + 1; end
            if (c == 2) busy3 = tx_busy;
        end
        rx_active = 0;
        checks++; if (n_disc !== 1 || disc_at !== 2) begin failures++; $display("FAIL disc_pulse n=%0d at=%0d exp n=1 at=2", n_disc, disc_at); end
        checks++; if (n_wait !== 0) begin failures++; $display("FAIL disc_wait got=%0d exp=0", n_wait); end
        checks++; if (busy3 !== 1'b0) begin failures++; $display("FAIL disc_busy got=%b exp=0", busy3); end
    endtask

    task automatic test_simultaneous();
        int n_hi, n_lo, hsent_at, sent_at, n_disc;
        logic busy_gap;
        n_hi = 0; n_lo = 0; hsent_at = -1; sent_at = -1; n_disc = 0; busy_gap = 1'bx;
        for (int c = 0; c < 23; c++) begin
            tx_send = (c == 0); tx_hrst_req = (c == 0);
            ifrgap_en = (c == 3) || (c == 12); transwin_en = (c == 5) || (c == 14);
            tx_sop_rst_cmplt = (c == 9); tx_eop_cmplt = (c == 18);
            tick();
            if (transmit_en && tx_hrst) n_hi++;
            if (transmit_en && !tx_hrst) n_lo++;
            if (hrstsent) hsent_at = c + 1;
            if (txmsgsent) sent_at = c + 1;
            if (txmsgdisc) n_disc++;
            if (c == 9) busy_gap = tx_busy;
        end
        checks++; if (n_hi !== 6) begin failures++; $display("FAIL sim_hrst_frame got=%0d exp=6", n_hi); end
        checks++; if (n_lo !== 6) begin failures++; $display("FAIL sim_msg_frame got=%0d exp=6", n_lo); end
        checks++; if (hsent_at !== 10) begin failures++; $display("FAIL sim_hrstsent at=%0d exp=10", hsent_at); end
        checks++; if (sent_at !== 19) begin failures++; $display("FAIL sim_msgsent at=%0d exp=19", sent_at); end
        checks++; if (busy_gap !== 1'b1) begin failures++; $display("FAIL sim_busy_pend got=%b exp=1", busy_gap); end
        checks++; if (n_disc !== 0) begin failures++; $display("FAIL sim_disc got=%0d exp=0", n_disc); end
    endtask

    task automatic test_hrst_abort();
        int abt_at, n_abt, hsent_at, n_hi, n_sent;
        logic gap_after;
        abt_at = -1; n_abt = 0; hsent_at = -1; n_hi = 0; n_sent = 0; gap_after = 1'bx;
        for (int c = 0; c < 21; c++) begin
            tx_send = (c == 0); tx_hrst_req = (c == 8);
            ifrgap_en = (c == 4) || (c == 11); transwin_en = (c == 6) || (c == 13);
            tx_sop_rst_cmplt = (c == 16);
            tick();
            if (txmsgabt) begin n_abt++; abt_at = c + 1; end
            if (c == 9) gap_after = wait_en && !transmit_en;
            if (tx_hrst) n_hi++;
            if (hrstsent) hsent_at = c + 1;
            if (txmsgsent) n_sent++;
        end
        checks++; if (n_abt !== 1 || abt_at !== 10) begin failures++; $display("FAIL abt_pulse n=%0d at=%0d exp n=1 at=10", n_abt, abt_at); end
        checks++; if (gap_after !== 1'b1) begin failures++; $display("FAIL abt_gap got=%b exp=1", gap_after); end
        checks++; if (n_hi !== 5) begin failures++; $display("FAIL abt_hrst_frame got=%0d exp=5", n_hi); end
        checks++; if (hsent_at !== 17) begin failures++; $display("FAIL abt_hrstsent at=%0d exp=17", hsent_at); end
        checks++; if (n_sent !== 0) begin failures++; $display("FAIL abt_msgsent got=%0d exp=0", n_sent); end
    endtask

    task automatic test_watchdog();
        int n_abt, abt_at, n_other;
        logic bmc_before, bmc_after;
        n_abt = 0; abt_at = -1; n_other = 0; bmc_before = 1'bx; bmc_after = 1'bx;
        for (int c = 0; c < 37; c++) begin
            tx_send = (c == 0); ifrgap_en = (c == 2); transwin_en = (c == 3);
            hbit_clk_red = (c >= 4) && (c % 4 == 0);
            tick();
            if (txmsgabt) begin n_abt++; abt_at = c + 1; end
            if (txmsgsent || hrstdisc || txmsgdisc) n_other++;
            if (c == 31) bmc_before = bmc_en;
            if (c == 32) bmc_after = bmc_en;
        end
        checks++; if (n_abt !== 1 || abt_at !== 33) begin failures++; $display("FAIL wd_abt n=%0d at=%0d exp n=1 at=33", n_abt, abt_at); end
        checks++; if (bmc_before !== 1'b1 || bmc_after !== 1'b0) begin failures++; $display("FAIL wd_bmc before=%b after=%b exp 1/0", bmc_before, bmc_after); end
        checks++; if (n_other !== 0) begin failures++; $display("FAIL wd_stray got=%0d exp=0", n_other); end
    endtask

    task automatic test_ucpd_en();
        int n_pulse;
        logic [9:0] obs_off;
        logic in_gap, busy_on;
        n_pulse = 0; obs_off = 'x; in_gap = 1'bx; busy_on = 1'bx;
        for (int c = 0; c < 9; c++) begin
            tx_send = (c == 0) || (c == 4);
            ucpd_en = !((c == 3) || (c == 4));
            tick();
            if (txmsgsent || txmsgdisc || txmsgabt || hrstsent || hrstdisc) n_pulse++;
            if (c == 2) in_gap = wait_en;
            if (c == 3) obs_off = obs;
            if (c == 5) busy_on = tx_busy;
        end
        ucpd_en = 1;
        checks++; if (in_gap !== 1'b1) begin failures++; $display("FAIL en_gap got=%b exp=1", in_gap); end
        checks++; if (obs_off !== 10'b0) begin failures++; $display("FAIL en_off obs=%b exp=%b", obs_off, 10'b0); end
        checks++; if (busy_on !== 1'b0) begin failures++; $display("FAIL en_ignored got=%b exp=0", busy_on); end
        checks++; if (n_pulse !== 0) begin failures++; $display("FAIL en_pulse got=%0d exp=0", n_pulse); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            ucpd_en = ($urandom_range(0, 199) != 0);
            tx_send = ($urandom_range(0, 99) < 5);
            tx_hrst_req = ($urandom_range(0, 99) < 2);
            rx_active = ($urandom_range(0, 9) < 2);
            ifrgap_en = ($urandom_range(0, 99) < 20);
            transwin_en = ($urandom_range(0, 99) < 25);
            hbit_clk_red = ($urandom_range(0, 99) < 30);
            tx_eop_cmplt = ($urandom_range(0, 99) < 5);
            tx_sop_rst_cmplt = ($urandom_range(0, 99) < 10);
            tick();
            checks++;
            if (obs !== exp_obs) begin
                failures++;
                $display("FAIL rand_cycle cyc=%0d obs=%b exp=%b", c, obs, exp_obs);
            end
            checks++;
            if ((wait_en && transmit_en) || (bmc_en && !transmit_en)) begin
                failures++;
                $display("FAIL rand_excl cyc=%0d wait=%b tx=%b bmc=%b", c, wait_en, transmit_en, bmc_en);
            end
        end
        ucpd_en = 1; rx_active = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_msg_send();
        test_rx_discard();
        test_simultaneous();
        test_hrst_abort();
        test_watchdog();
        test_ucpd_en();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
